dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have ports: clk_i  in  1  system clock, single clock domain.
REQ-002 SHALL have ports: rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: req0_i/we0_i  in  1/1  core LSU request / write enable.
REQ-004 SHALL have ports: addr0_i/wd0_i/be0_i  in  32/32/4  core address / write data / byte enable.
REQ-005 SHALL have ports: rd0_o  out  32  core read data; stall0_o  out  1  core stall.
REQ-006 SHALL have ports: req1_i/we1_i  in  1/1, addr1_i/wd1_i/be1_i  in  32/32/4  DMA master request set.
REQ-007 SHALL have ports: rd1_o  out  32; stall1_o  out  1  DMA read data / stall.
REQ-008 SHALL have ports: mem_req_o/mem_we_o  out  1/1, mem_addr_o/mem_wd_o/mem_be_o  out  32/32/4  memory side.
REQ-009 SHALL have port mem_rd_i  in  32, valid exactly one cycle after the mem_req_o cycle.

Function
REQ-010 SHALL implement FSM states IDLE, DONE0, DONE1, where DONEx means requester x's access issued last cycle.
REQ-011 Grant SHALL be combinational in IDLE/DONEx: winner's we/addr/wd/be drive mem_*_o with mem_req_o=1 in the same cycle; next state DONE<winner>.
REQ-012 In DONEx, requester x SHALL be excluded from arbitration; only the other requester may be granted (back-to-back issue).
REQ-013 With no eligible request, mem_req_o SHALL be 0, mem_we_o 0, mem_be_o 0, mem_addr_o/mem_wd_o 0; next state IDLE.
REQ-014 stall_x_o SHALL equal req_x_i AND NOT (state==DONEx).
REQ-015 Uncontended access SHALL give stall high in the issue cycle and low exactly the next cycle (one-cycle stall).
REQ-016 rd_x_o SHALL equal mem_rd_i in DONEx, and 0 otherwise.
REQ-017 Writes SHALL complete identically to reads (DONEx cycle releases stall; rd_x_o value ignored).
REQ-018 A requester SHALL hold req/we/addr/wd/be stable while its stall is high; the arbiter does not latch request fields.
REQ-019 A request dropped while waiting (req_x_i falls before grant) SHALL be discarded without a memory access.
REQ-020 Requester x asserting req_x_i in the cycle after DONEx SHALL be a new request, arbitrated normally.
REQ-021 last_grant register SHALL record the winner of every issued access.

Reset
REQ-022 rst_i SHALL force state IDLE and last_grant=1 immediately, regardless of clock.
REQ-023 During reset all outputs SHALL be 0 (mem_req_o=0, stall0_o=stall1_o=0, rd0_o=rd1_o=0).
REQ-024 Reset mid-access SHALL drop the in-flight access; the requester reissues after reset.

Configuration
REQ-025 Macro DMEM_ARB_RR_EN defined: simultaneous eligible requests in IDLE SHALL go to the requester not equal to last_grant (round-robin).
REQ-026 Macro DMEM_ARB_RR_EN undefined: requester 0 (core) SHALL always win ties; last_grant still maintained but unused for arbitration.

Structure
REQ-027 Package dmem_arb_pkg SHALL hold the FSM state enum, requester ID constants (REQ_CORE=0, REQ_DMA=1), and ADDR_W=32, DATA_W=32, BE_W=4.
REQ-028 Winner selection SHALL live in sub-module dmem_arb_picker (inputs: eligible vector, last_grant; output: grant id, grant valid).

Verification
REQ-029 Core-only load: req0=1, addr0=0x0000_0010, mem returns 0xDEAD_BEEF -> stall0 high 1 cycle, rd0_o=0xDEAD_BEEF in DONE0, mem_req_o 1 cycle.
REQ-030 Simultaneous req0/req1 in IDLE after reset, RR enabled -> core issued first (last_grant=1), DMA issued the next cycle; stall1 high 2 cycles.
REQ-031 Same stimulus with macro undefined, both held requesting continuously -> core wins every tie; DMA granted only in DONE0 cycles.
REQ-032 DMA write addr1=0x100, wd1=0x1234_5678, be1=4'b0011 -> mem_we_o=1, mem_be_o=4'b0011, mem_wd_o=0x1234_5678 for one cycle; stall1 low next cycle.
REQ-033 Assert rst_i asynchronously in DONE1 -> state IDLE, all outputs 0 same cycle; no rd1_o capture.
REQ-034 Assertions: mem_req_o for core implies stall0_o now or $past(stall0_o); uncontended stall0_o rise |=> fall.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg -- shared types and constants for the data-memory arbiter.
//
// Contents:
//   ADDR_W / DATA_W / BE_W   memory bus widths
//   REQ_CORE / REQ_DMA       requester IDs (also the grant_id encoding)
//   arb_state_t              FSM state: IDLE, DONE0, DONE1
//   done_state()             maps a requester ID to its DONEx state
package dmem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DMA  = 1'b1;

    // DONEx: requester x had its access issued in the previous cycle, so
    // mem_rd_i currently carries its response.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DONE0 = 2'd1,
        DONE1 = 2'd2
    } arb_state_t;

    function automatic arb_state_t done_state(input logic id);
        return (id == REQ_DMA) ? DONE1 : DONE0;
    endfunction

endpackage

// File: rtl/dmem_arb_picker.sv
// dmem_arb_picker -- combinational winner selection for the two requesters.
//
// Parameters:
//   RR_EN        1: ties go to the requester other than last_grant
//                0: ties always go to the core (requester 0)
// Ports:
//   eligible     in  2  per-requester "may be granted this cycle"
//   last_grant   in  1  winner of the most recent issued access
//   grant_id     out 1  winning requester (REQ_CORE / REQ_DMA)
//   grant_valid  out 1  at least one requester is eligible
module dmem_arb_picker
    import dmem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       grant_id,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |eligible;
        grant_id    = REQ_CORE;
        if (eligible == 2'b11) begin
            grant_id = RR_EN ? ~last_grant : REQ_CORE;
        end else if (eligible[1]) begin
            grant_id = REQ_DMA;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- two-master (core LSU + DMA) arbiter in front of a
// single-port data memory with one-cycle read latency.
//
// Configuration macro:
//   DMEM_ARB_RR_EN  defined   -> round-robin tie-break using last_grant
//                   undefined -> core always wins ties (default build)
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   req0_i/we0_i/addr0_i/wd0_i/be0_i  core request fields (held while stalled)
//   rd0_o, stall0_o                   core read data / stall
//   req1_i/we1_i/addr1_i/wd1_i/be1_i  DMA request fields (held while stalled)
//   rd1_o, stall1_o                   DMA read data / stall
//   mem_req_o/mem_we_o/mem_addr_o/
//   mem_wd_o/mem_be_o                 memory request, driven combinationally
//   mem_rd_i                          memory read data, valid one cycle after
//                                     the mem_req_o cycle
//
// Request fields are never latched: the winner's inputs go straight to the
// memory port in the grant cycle, and the following DONEx cycle routes
// mem_rd_i back and drops that requester's stall.
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic [BE_W-1:0]   be0_i,
    output logic [DATA_W-1:0] rd0_o,
    output logic              stall0_o,

    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wd1_i,
    input  logic [BE_W-1:0]   be1_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic              stall1_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    output logic [BE_W-1:0]   mem_be_o,
    input  logic [DATA_W-1:0] mem_rd_i
);

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    arb_state_t state;
    logic       last_grant;

    logic [1:0] req_vec;
    logic [1:0] done_vec;
    logic [1:0] eligible;
    logic [1:0] stall_vec;
    logic       grant_id;
    logic       grant_valid;

    assign req_vec = {req1_i, req0_i};

    // Per-requester eligibility and stall. A requester whose access was
    // issued last cycle is sitting in its completion cycle: it is neither
    // stalled nor eligible, so the other requester can issue back-to-back.
    // Everything is masked while rst_i is high so outputs are zero
    // throughout reset, not just after the next edge.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign done_vec[gi]  = (state == done_state(gi[0]));
            assign eligible[gi]  = req_vec[gi] & ~done_vec[gi] & ~rst_i;
            assign stall_vec[gi] = req_vec[gi] & ~done_vec[gi] & ~rst_i;
        end
    endgenerate

    assign stall0_o = stall_vec[0];
    assign stall1_o = stall_vec[1];
    assign rd0_o    = (done_vec[0] && !rst_i) ? mem_rd_i : '0;
    assign rd1_o    = (done_vec[1] && !rst_i) ? mem_rd_i : '0;

    dmem_arb_picker #(
        .RR_EN       (RR_EN)
    ) u_picker (
        .eligible    (eligible),
        .last_grant  (last_grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Memory side: winner's fields pass through; all-zero when idle.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_wd_o   = '0;
        mem_be_o   = '0;
        if (grant_valid) begin
            mem_req_o = 1'b1;
            if (grant_id == REQ_DMA) begin
                mem_we_o   = we1_i;
                mem_addr_o = addr1_i;
                mem_wd_o   = wd1_i;
                mem_be_o   = be1_i;
            end else begin
                mem_we_o   = we0_i;
                mem_addr_o = addr0_i;
                mem_wd_o   = wd0_i;
                mem_be_o   = be0_i;
            end
        end
    end

    // last_grant resets to the DMA so the first tie after reset goes to the
    // core in round-robin mode as well.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= REQ_DMA;
        end else if (grant_valid) begin
            state      <= done_state(grant_id);
            last_grant <= grant_id;
        end else begin
            state      <= IDLE;
        end
    end

    // A core access only reaches memory while the core is being held off.
    a_core_grant_stalled: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (mem_req_o && grant_id == REQ_CORE) |-> (stall0_o || $past(stall0_o))
    );

    // With the DMA quiet, a core stall lasts exactly one cycle.
    a_core_single_stall: assert property (
        @(posedge clk_i) disable iff (rst_i)
        ($rose(stall0_o) && !req1_i) |=> !stall0_o
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- directed vector table followed by randomized traffic
// from two protocol-following requesters, checked against a reference model
// built from the arbitration rules and a word-addressed memory array.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wd0, addr1, wd1;
    logic [3:0]  be0, be1;
    logic [31:0] rd0, rd1;
    logic        stall0, stall1;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic [3:0]  mem_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req0_i     (req0),
        .we0_i      (we0),
        .addr0_i    (addr0),
        .wd0_i      (wd0),
        .be0_i      (be0),
        .rd0_o      (rd0),
        .stall0_o   (stall0),
        .req1_i     (req1),
        .we1_i      (we1),
        .addr1_i    (addr1),
        .wd1_i      (wd1),
        .be1_i      (be1),
        .rd1_o      (rd1),
        .stall1_o   (stall1),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wd_o   (mem_wd),
        .mem_be_o   (mem_be),
        .mem_rd_i   (mem_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Checks every DUT output against the given expectations.
    task automatic chk_all(input string tag,
                           input bit e_req, input bit e_we, input logic [31:0] e_addr,
                           input logic [31:0] e_wd, input logic [3:0] e_be,
                           input bit e_s0, input bit e_s1,
                           input logic [31:0] e_rd0, input logic [31:0] e_rd1);
        chk({tag, " mem_req"},  {31'b0, mem_req}, {31'b0, e_req});
        chk({tag, " mem_we"},   {31'b0, mem_we},  {31'b0, e_we});
        chk({tag, " mem_addr"}, mem_addr, e_addr);
        chk({tag, " mem_wd"},   mem_wd, e_wd);
        chk({tag, " mem_be"},   {28'b0, mem_be}, {28'b0, e_be});
        chk({tag, " stall0"},   {31'b0, stall0}, {31'b0, e_s0});
        chk({tag, " stall1"},   {31'b0, stall1}, {31'b0, e_s1});
        chk({tag, " rd0"},      rd0, e_rd0);
        chk({tag, " rd1"},      rd1, e_rd1);
    endtask

    // Directed vectors: core always reads 0x10 (wd 0xCAFE0000, be 0xF),
    // DMA always targets 0x100 (wd 0x12345678, be 0011); per-cycle we1.
    typedef struct {
        bit          rst;
        bit          r0;
        bit          r1;
        bit          we1;
        logic [31:0] mrd;
        bit          e_req;
        bit          e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        bit          e_s0;
        bit          e_s1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    function automatic vec_t mk(bit r, bit a, bit b, bit w, logic [31:0] mrd,
                                int gnt, bit gwe, bit s0, bit s1,
                                logic [31:0] x0, logic [31:0] x1);
        vec_t v;
        v.rst = r; v.r0 = a; v.r1 = b; v.we1 = w; v.mrd = mrd;
        v.e_req = (gnt >= 0);
        v.e_we  = (gnt >= 0) ? gwe : 1'b0;
        v.e_addr = (gnt == 0) ? 32'h10 : (gnt == 1) ? 32'h100 : 32'h0;
        v.e_wd   = (gnt == 0) ? 32'hCAFE_0000 : (gnt == 1) ? 32'h1234_5678 : 32'h0;
        v.e_be   = (gnt == 0) ? 4'hF : (gnt == 1) ? 4'b0011 : 4'h0;
        v.e_s0 = s0; v.e_s1 = s1; v.e_rd0 = x0; v.e_rd1 = x1;
        return v;
    endfunction

    // Random-phase state
    bit          act [2];
    bit          rwe [2];
    logic [31:0] rad [2];
    logic [31:0] rwd [2];
    logic [3:0]  rbe [2];
    logic [31:0] mem [64];

    initial begin
        int          issued;   // requester whose access was issued last cycle, -1 none
        bit          lastg;
        int          win;
        bit          e0, e1, done_now0, done_now1;
        logic [31:0] next_rd;

        //      rst r0 r1 we1 mem_rd        gnt we s0 s1 rd0            rd1
        tbl[0]  = mk(0, 0, 1, 1, 32'h0,         1, 1, 0, 1, 32'h0,         32'h0);          // DMA write
        tbl[1]  = mk(0, 0, 0, 0, 32'h5555_5555, -1, 0, 0, 0, 32'h0,         32'h5555_5555);
        tbl[2]  = mk(0, 1, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0,         32'h0);          // core load
        tbl[3]  = mk(0, 0, 0, 0, 32'hDEAD_BEEF, -1, 0, 0, 0, 32'hDEAD_BEEF, 32'h0);
        tbl[4]  = mk(0, 0, 0, 0, 32'h7777_7777, -1, 0, 0, 0, 32'h0,         32'h0);          // idle
        tbl[5]  = mk(0, 0, 1, 0, 32'h0,         1, 0, 0, 1, 32'h0,         32'h0);          // DMA read
        tbl[6]  = mk(1, 1, 1, 0, 32'hAAAA_AAAA, -1, 0, 0, 0, 32'h0,         32'h0);          // reset in DONE1
        tbl[7]  = mk(0, 1, 1, 0, 32'h0,         0, 0, 1, 1, 32'h0,         32'h0);          // tie -> core
        tbl[8]  = mk(0, 0, 1, 0, 32'h1111_1111, 1, 0, 0, 1, 32'h1111_1111, 32'h0);
        tbl[9]  = mk(0, 0, 0, 0, 32'h2222_2222, -1, 0, 0, 0, 32'h0,         32'h2222_2222);
        tbl[10] = mk(0, 0, 0, 0, 32'h3333_3333, -1, 0, 0, 0, 32'h0,         32'h0);
        tbl[11] = mk(0, 1, 1, 0, 32'h0,         0, 0, 1, 1, 32'h0,         32'h0);          // both held
        tbl[12] = mk(0, 1, 1, 0, 32'h4444_4444, 1, 0, 0, 1, 32'h4444_4444, 32'h0);
        tbl[13] = mk(0, 1, 1, 0, 32'h6666_6666, 0, 0, 1, 0, 32'h0,         32'h6666_6666);
        tbl[14] = mk(0, 1, 1, 0, 32'h8888_8888, 1, 0, 0, 1, 32'h8888_8888, 32'h0);
        tbl[15] = mk(0, 0, 0, 0, 32'h9999_9999, -1, 0, 0, 0, 32'h0,         32'h9999_9999);

        // Reset with both requesters asserting: every output must be zero.
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;  wd0 = 32'hCAFE_0000; be0 = 4'hF;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h100; wd1 = 32'h1234_5678; be1 = 4'b0011;
        mem_rd = 32'hFFFF_FFFF;
        @(negedge clk);
        chk_all("reset", 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            rst    = tbl[i].rst;
            req0   = tbl[i].r0;
            req1   = tbl[i].r1;
            we1    = tbl[i].we1;
            mem_rd = tbl[i].mrd;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_we, tbl[i].e_addr,
                    tbl[i].e_wd, tbl[i].e_be, tbl[i].e_s0, tbl[i].e_s1,
                    tbl[i].e_rd0, tbl[i].e_rd1);
        end

        // Randomized traffic from a clean reset.
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int x = 0; x < 2; x++) act[x] = 1'b0;
        issued  = -1;
        lastg   = 1'b1;
        next_rd = $urandom;

        for (int cyc = 0; cyc < 2500; cyc++) begin
            if (cyc != 0) begin
                @(posedge clk); #1;
            end
            // Requesters: hold while pending, may abandon a pending request,
            // start a fresh one after completing.
            done_now0 = act[0] && issued == 0;
            done_now1 = act[1] && issued == 1;
            for (int x = 0; x < 2; x++) begin
                if (act[x] && issued == x) begin
                    // completion cycle: keep fields stable
                end else if (act[x]) begin
                    if ($urandom_range(7) == 0) act[x] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    act[x] = 1'b1;
                    rwe[x] = 1'($urandom_range(1));
                    rad[x] = 32'($urandom_range(63)) << 2;
                    rwd[x] = $urandom;
                    rbe[x] = 4'($urandom_range(15));
                end
            end
            req0 = act[0]; we0 = rwe[0]; addr0 = rad[0]; wd0 = rwd[0]; be0 = rbe[0];
            req1 = act[1]; we1 = rwe[1]; addr1 = rad[1]; wd1 = rwd[1]; be1 = rbe[1];
            mem_rd = next_rd;

            // Reference: a requester just served is skipped this cycle.
            e0 = act[0] && issued != 0;
            e1 = act[1] && issued != 1;
            if (e0 && e1) begin
`ifdef DMEM_ARB_RR_EN
                win = lastg ? 0 : 1;
`else
                win = 0;
`endif
            end else if (e0) win = 0;
            else if (e1)     win = 1;
            else             win = -1;

            @(negedge clk);
            if (win >= 0)
                chk_all($sformatf("rnd%0d", cyc), 1'b1, rwe[win], rad[win], rwd[win], rbe[win],
                        e0, e1, (issued == 0) ? mem_rd : 32'h0, (issued == 1) ? mem_rd : 32'h0);
            else
                chk_all($sformatf("rnd%0d", cyc), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                        e0, e1, (issued == 0) ? mem_rd : 32'h0, (issued == 1) ? mem_rd : 32'h0);

            // Memory model: reads return the array word next cycle; writes
            // merge the enabled bytes.
            next_rd = $urandom;
            if (win >= 0) begin
                if (rwe[win]) begin
                    for (int b = 0; b < 4; b++)
                        if (rbe[win][b]) mem[rad[win][7:2]][8*b +: 8] = rwd[win][8*b +: 8];
                end else begin
                    next_rd = mem[rad[win][7:2]];
                end
                lastg = win[0];
            end
            issued = win;
            if (done_now0) act[0] = 1'b0;
            if (done_now1) act[1] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
